// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-locking write-port arbiter for async_fifo
// Optional stall counter output enabled by FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     wclk,
    input  logic                     wreset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DW-1:0]       data,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DW-1:0]            wdata,
    input  logic                     full,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     timeout_err
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   owner_q;
    logic [7:0]      idle_cnt_q;
    logic            timeout_err_q;

    logic [PW-1:0]   sel_d;
    logic            found_d;
    int              idx_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
    endfunction

    // Grant path is purely combinational: zero-latency accept of the current beat.
    always_comb begin
        gnt     = '0;
        sel_d   = owner_q;
        found_d = 1'b0;
        idx_d   = 0;
        if (!wreset && !full) begin
            if (state_q == IDLE) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx_d = (int'(rr_ptr_q) + k) % NREQ;
                    if (!found_d && req[idx_d]) begin
                        found_d = 1'b1;
                        sel_d   = PW'(idx_d);
                    end
                end
            end else if (req[owner_q]) begin
                found_d = 1'b1;
            end
        end
        if (found_d) gnt[sel_d] = 1'b1;
    end

    assign winc        = found_d;
    assign wdata       = found_d ? data[int'(sel_d)*DW +: DW] : '0;
    assign owner       = owner_q;
    assign busy        = (state_q == LOCKED);
    assign timeout_err = timeout_err_q;

    always_ff @(posedge wclk) begin
        if (wreset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        if (last[sel_d]) begin
                            rr_ptr_q <= next_ptr(sel_d);
                        end else begin
                            state_q    <= LOCKED;
                            owner_q    <= sel_d;
                            idle_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (found_d) begin
                        idle_cnt_q <= '0;
                        if (last[owner_q]) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr(owner_q);
                        end
                    end else if (!req[owner_q]) begin
                        // Stalls caused by full do not count toward the watchdog.
                        if (idle_cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                            state_q       <= IDLE;
                            timeout_err_q <= 1'b1;
                            rr_ptr_q      <= next_ptr(owner_q);
                            idle_cnt_q    <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        considered_d;

    assign considered_d = (state_q == IDLE) ? |req : req[owner_q];
    assign stall_cnt    = stall_cnt_q;

    always_ff @(posedge wclk) begin
        if (wreset) begin
            stall_cnt_q <= '0;
        end else if (full && considered_d && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`endif

endmodule
